// File: rtl/fixed_point_acc_arbiter_if.sv
// Requester and accumulator-side signal bundle for fixed_point_acc_arbiter.
// slave = arbiter view, master = layer control / accumulator environment view.
interface fixed_point_acc_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 16
);
    logic [NUM_REQ-1:0]                  REQ_VALID_IN;
    logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0] REQ_VALUES_IN;
    logic [NUM_REQ*WIDTH-1:0]            REQ_BIAS_IN;
    logic [NUM_REQ-1:0]                  REQ_READY_OUT;
    logic [NUM_REQ-1:0]                  RESP_VALID_OUT;
    logic [WIDTH-1:0]                    RESP_VALUE_OUT;
    logic                                RESP_ERR_OUT;
    logic                                ACC_RSTN_OUT;
    logic [NUM_INPUTS*WIDTH-1:0]         ACC_VALUES_OUT;
    logic [WIDTH-1:0]                    ACC_BIAS_OUT;
    logic                                ACC_VALID_OUT;
    logic [WIDTH-1:0]                    ACC_VALUE_IN;
    logic                                ACC_VALID_IN;

    modport slave (
        input  REQ_VALID_IN, REQ_VALUES_IN, REQ_BIAS_IN, ACC_VALUE_IN, ACC_VALID_IN,
        output REQ_READY_OUT, RESP_VALID_OUT, RESP_VALUE_OUT, RESP_ERR_OUT,
               ACC_RSTN_OUT, ACC_VALUES_OUT, ACC_BIAS_OUT, ACC_VALID_OUT
    );

    modport master (
        output REQ_VALID_IN, REQ_VALUES_IN, REQ_BIAS_IN, ACC_VALUE_IN, ACC_VALID_IN,
        input  REQ_READY_OUT, RESP_VALID_OUT, RESP_VALUE_OUT, RESP_ERR_OUT,
               ACC_RSTN_OUT, ACC_VALUES_OUT, ACC_BIAS_OUT, ACC_VALID_OUT
    );
endinterface

// File: rtl/fixed_point_acc_arbiter.sv
// Round-robin share of one fixed-point accumulator among NUM_REQ requesters; ACC_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: grant -> CLEAR -> ISSUE -> WAIT(accumulator) -> RESP, one request in flight.
// Backpressure: requests hold REQ_VALID_IN until the one-cycle REQ_READY_OUT grant pulse; others wait.
module fixed_point_acc_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 3,
    parameter int NUM_INPUTS = 16,
    parameter int TIMEOUT    = 64
) (
    input logic                      CLK,
    input logic                      RSTN,
    fixed_point_acc_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VEC_W = NUM_INPUTS * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_X = (IDX_W + 1)'(NUM_REQ);

    if (NUM_REQ < 2 || FRAC_BITS < 0 || FRAC_BITS >= WIDTH || TIMEOUT < 2) begin : g_bad_cfg
        $error("fixed_point_acc_arbiter: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [VEC_W-1:0]   values_q, values_d;
    logic [WIDTH-1:0]   bias_q, bias_d;
    logic [WIDTH-1:0]   resp_value_q, resp_value_d;

`ifdef ACC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_err_q, resp_err_d;
`endif

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_off;
    logic [IDX_W:0]       pick_sum;
    logic [IDX_W-1:0]     pick_idx;

    // Rotate requests so bit 0 is the pointer; the lowest set bit is the winner's offset.
    always_comb begin
        req_dbl  = {bus.REQ_VALID_IN, bus.REQ_VALID_IN} >> ptr_q;
        req_rot  = req_dbl[NUM_REQ-1:0];
        pick_vld = |req_rot;
        pick_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) pick_off = IDX_W'(i);
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= NUM_REQ_X) pick_sum = pick_sum - NUM_REQ_X;
        pick_idx = pick_sum[IDX_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        values_d     = values_q;
        bias_d       = bias_q;
        resp_value_d = resp_value_q;
`ifdef ACC_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IDX_W'(i)) begin
                            values_d = bus.REQ_VALUES_IN[i*VEC_W +: VEC_W];
                            bias_d   = bus.REQ_BIAS_IN[i*WIDTH +: WIDTH];
                        end
                    end
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ISSUE;
            S_ISSUE: begin
`ifdef ACC_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ACC_VALID_IN) begin
                    resp_value_d = bus.ACC_VALUE_IN;
`ifdef ACC_ARB_TIMEOUT_EN
                    resp_err_d   = 1'b0;
`endif
                    state_d      = S_RESP;
                end
`ifdef ACC_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    resp_value_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            values_q     <= '0;
            bias_q       <= '0;
            resp_value_q <= '0;
`ifdef ACC_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            values_q     <= values_d;
            bias_q       <= bias_d;
            resp_value_q <= resp_value_d;
`ifdef ACC_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // Pulses are gated by RSTN so an aborted request never produces a grant or response.
    assign bus.REQ_READY_OUT  = (RSTN && state_q == S_IDLE && pick_vld) ? (NUM_REQ'(1) << pick_idx) : '0;
    assign bus.RESP_VALID_OUT = (RSTN && state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.RESP_VALUE_OUT = resp_value_q;
    assign bus.ACC_RSTN_OUT   = RSTN && (state_q != S_CLEAR);
    assign bus.ACC_VALID_OUT  = RSTN && (state_q == S_ISSUE);
    assign bus.ACC_VALUES_OUT = values_q;
    assign bus.ACC_BIAS_OUT   = bias_q;
`ifdef ACC_ARB_TIMEOUT_EN
    assign bus.RESP_ERR_OUT   = resp_err_q;
`else
    assign bus.RESP_ERR_OUT   = 1'b0;
`endif
endmodule
